// File: rtl/histogram_peak_finder.sv
// Sweeps a frozen histogram through a one-cycle-latency read port and reports
// the peak bin, its count, the sum of all bins and the number of non-empty bins.
module histogram_peak_finder #(
   parameter int SIZE       = 7,
   parameter int MAX_NUMBER = 127,
   parameter int ADDR_W     = $clog2(MAX_NUMBER)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   START,
   output logic [ADDR_W-1:0]      rd_addr,
   input  logic [SIZE-1:0]        rd_data,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [ADDR_W-1:0]      peak_bin,
   output logic [SIZE-1:0]        peak_count,
   output logic [SIZE+ADDR_W-1:0] total,
   output logic [ADDR_W:0]        nonzero_bins
);

   localparam int SUM_W = SIZE + ADDR_W;
   localparam int NZ_W  = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_NUMBER);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [SIZE-1:0]    max_q, max_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [SUM_W-1:0]   sum_q, sum_d;
   logic [NZ_W-1:0]    nz_q, nz_d;
   logic [ADDR_W-1:0]  peak_bin_q, peak_bin_d;
   logic [SIZE-1:0]    peak_count_q, peak_count_d;
   logic [SUM_W-1:0]   total_q, total_d;
   logic [NZ_W-1:0]    nonzero_q, nonzero_d;
   logic               sample_en;
   logic [ADDR_W-1:0]  sample_idx;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         max_q        <= '0;
         idx_q        <= '0;
         sum_q        <= '0;
         nz_q         <= '0;
         peak_bin_q   <= '0;
         peak_count_q <= '0;
         total_q      <= '0;
         nonzero_q    <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         max_q        <= max_d;
         idx_q        <= idx_d;
         sum_q        <= sum_d;
         nz_q         <= nz_d;
         peak_bin_q   <= peak_bin_d;
         peak_count_q <= peak_count_d;
         total_q      <= total_d;
         nonzero_q    <= nonzero_d;
      end
   end

   // rd_data always belongs to the address presented one cycle earlier,
   // so the first READ cycle carries nothing and DRAIN carries the last bin.
   always_comb begin
      sample_en  = ((state_q == READ) && (addr_q != '0)) || (state_q == DRAIN);
      sample_idx = (state_q == DRAIN) ? LAST_ADDR : addr_q - ADDR_W'(1);
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      max_d        = max_q;
      idx_d        = idx_q;
      sum_d        = sum_q;
      nz_d         = nz_q;
      peak_bin_d   = peak_bin_q;
      peak_count_d = peak_count_q;
      total_d      = total_q;
      nonzero_d    = nonzero_q;

      case (state_q)
         IDLE: begin
            if (START) begin
               state_d = READ;
               addr_d  = '0;
               max_d   = '0;
               idx_d   = '0;
               sum_d   = '0;
               nz_d    = '0;
            end
         end
         READ: begin
            if (addr_q == LAST_ADDR) begin
               state_d = DRAIN;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            state_d = FIN;
            addr_d  = '0;
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            addr_d  = '0;
         end
      endcase

      // Strictly-greater update keeps the lowest index on ties.
      if (sample_en) begin
         sum_d = sum_q + SUM_W'(rd_data);
         if (rd_data != '0) begin
            nz_d = nz_q + NZ_W'(1);
         end
         if (rd_data > max_q) begin
            max_d = rd_data;
            idx_d = sample_idx;
         end
      end

      if (state_q == DRAIN) begin
         peak_bin_d   = idx_d;
         peak_count_d = max_d;
         total_d      = sum_d;
         nonzero_d    = nz_d;
      end
   end

   assign rd_addr      = addr_q;
   assign BUSY         = (state_q == READ) || (state_q == DRAIN);
   assign DONE         = (state_q == FIN);
   assign peak_bin     = peak_bin_q;
   assign peak_count   = peak_count_q;
   assign total        = total_q;
   assign nonzero_bins = nonzero_q;

endmodule

// File: tb/tb_histogram_peak_finder.sv
// Drives histogram_peak_finder against a synchronous-read memory model and
// compares each sweep with statistics computed directly from the memory array.
module tb_histogram_peak_finder;

   localparam int SIZE = 7;
   localparam int MAXN = 127;
   localparam int AW   = 7;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              START = 1'b0;
   logic [AW-1:0]     rd_addr;
   logic [SIZE-1:0]   rd_data = '0;
   logic              BUSY;
   logic              DONE;
   logic [AW-1:0]     peak_bin;
   logic [SIZE-1:0]   peak_count;
   logic [SIZE+AW-1:0] total;
   logic [AW:0]       nonzero_bins;

   logic [SIZE-1:0]   mem [0:MAXN];

   int checks = 0;
   int passes = 0;
   int expPeak, expCount, expTotal, expNz;
   int prevPeak  = 0;
   int prevTotal = 0;

   histogram_peak_finder dut (
      .CLK          (CLK),
      .RST          (RST),
      .START        (START),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .BUSY         (BUSY),
      .DONE         (DONE),
      .peak_bin     (peak_bin),
      .peak_count   (peak_count),
      .total        (total),
      .nonzero_bins (nonzero_bins)
   );

   always #5 CLK = ~CLK;

   // Histogram memory: one-cycle read latency.
   always @(posedge CLK) rd_data <= mem[rd_addr];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   // Reference statistics: find the maximum value, then the first bin holding it.
   task automatic computeModel();
      bit found;
      expCount = 0;
      expTotal = 0;
      expNz    = 0;
      for (int i = 0; i <= MAXN; i++) begin
         if (int'(mem[i]) > expCount) expCount = int'(mem[i]);
         expTotal += int'(mem[i]);
         if (mem[i] != 0) expNz++;
      end
      expPeak = 0;
      found   = 1'b0;
      for (int i = 0; i <= MAXN; i++) begin
         if (!found && int'(mem[i]) == expCount) begin
            expPeak = i;
            found   = 1'b1;
         end
      end
   endtask

   task automatic fillConst(input int v);
      for (int i = 0; i <= MAXN; i++) mem[i] = SIZE'(v);
   endtask

   task automatic fillRandom(input bit sparse);
      for (int i = 0; i <= MAXN; i++) begin
         if (sparse && $urandom_range(0, 3) != 0) mem[i] = '0;
         else mem[i] = SIZE'($urandom_range(0, 127));
      end
   endtask

   // One full sweep: START pulse, per-cycle address/BUSY tracking, result checks.
   task automatic applyStimulus(input string tag, input bit extraStarts);
      int doneK;
      int addrErr;
      int busyErr;
      int busyAfter;
      computeModel();
      doneK   = -1;
      addrErr = 0;
      busyErr = 0;
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (DONE === 1'b1) begin
            doneK = k;
            break;
         end
         if (rd_addr !== AW'((k <= MAXN) ? k : MAXN)) addrErr++;
         if (BUSY !== 1'b1) busyErr++;
         if (k == 64) begin
            checkOutput({tag, " held peak_bin"}, 32'(peak_bin), 32'(prevPeak));
            checkOutput({tag, " held total"}, 32'(total), 32'(prevTotal));
         end
         START = extraStarts && (k == 5 || k == 60 || k == 128);
         @(negedge CLK);
      end
      START = 1'b0;
      checkOutput({tag, " latency"}, 32'(doneK), 32'(MAXN + 2));
      checkOutput({tag, " rd_addr seq errors"}, 32'(addrErr), 32'd0);
      checkOutput({tag, " busy drop errors"}, 32'(busyErr), 32'd0);
      checkOutput({tag, " busy at done"}, 32'(BUSY), 32'd0);
      checkOutput({tag, " peak_bin"}, 32'(peak_bin), 32'(expPeak));
      checkOutput({tag, " peak_count"}, 32'(peak_count), 32'(expCount));
      checkOutput({tag, " total"}, 32'(total), 32'(expTotal));
      checkOutput({tag, " nonzero_bins"}, 32'(nonzero_bins), 32'(expNz));
      @(negedge CLK);
      checkOutput({tag, " done pulse width"}, 32'(DONE), 32'd0);
      busyAfter = 0;
      repeat (3) begin
         if (BUSY !== 1'b0) busyAfter++;
         @(negedge CLK);
      end
      checkOutput({tag, " idle after done"}, 32'(busyAfter), 32'd0);
      prevPeak  = expPeak;
      prevTotal = expTotal;
   endtask

   // Abort a sweep halfway with an asynchronous reset between clock edges.
   task automatic resetAbortTest();
      int doneSeen;
      fillRandom(1'b0);
      @(negedge CLK);
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (64) @(negedge CLK);
      #2 RST = 1'b0;
      #1;
      checkOutput("abort rd_addr", 32'(rd_addr), 32'd0);
      checkOutput("abort busy", 32'(BUSY), 32'd0);
      checkOutput("abort done", 32'(DONE), 32'd0);
      checkOutput("abort peak_bin", 32'(peak_bin), 32'd0);
      checkOutput("abort peak_count", 32'(peak_count), 32'd0);
      checkOutput("abort total", 32'(total), 32'd0);
      checkOutput("abort nonzero_bins", 32'(nonzero_bins), 32'd0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      doneSeen = 0;
      repeat (140) begin
         @(negedge CLK);
         if (DONE !== 1'b0) doneSeen++;
      end
      checkOutput("abort no done", 32'(doneSeen), 32'd0);
      prevPeak  = 0;
      prevTotal = 0;
   endtask

   initial begin
      fillConst(0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      checkOutput("reset busy", 32'(BUSY), 32'd0);
      checkOutput("reset done", 32'(DONE), 32'd0);
      checkOutput("reset rd_addr", 32'(rd_addr), 32'd0);
      checkOutput("reset total", 32'(total), 32'd0);
      RST = 1'b1;
      @(negedge CLK);

      fillConst(0);
      applyStimulus("zero", 1'b0);

      fillConst(5);
      mem[37] = 7'd90;
      applyStimulus("bin37", 1'b0);
      checkOutput("bin37 literal total", 32'(total), 32'd725);

      resetAbortTest();
      applyStimulus("fresh after abort", 1'b0);

      fillConst(0);
      mem[10]  = 7'd127;
      mem[100] = 7'd127;
      applyStimulus("tie", 1'b0);
      checkOutput("tie literal peak_bin", 32'(peak_bin), 32'd10);

      fillConst(127);
      applyStimulus("saturate", 1'b0);
      checkOutput("saturate literal total", 32'(total), 32'd16256);

      fillRandom(1'b0);
      applyStimulus("random dense", 1'b0);
      fillRandom(1'b1);
      applyStimulus("random sparse", 1'b0);
      fillRandom(1'b0);
      applyStimulus("extra starts", 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/histogram_peak_finder.md
# histogram_peak_finder

Post-processing stage downstream of `histogram_unit`. On a start request, it sweeps every histogram bin through a synchronous one-cycle-latency read port and reports:
- the peak bin index and its count,
- the sum of all bin counts,
- the number of non-empty bins.

The upstream histogram must be frozen (its ENA held low) for the whole sweep. This block does not check that.

## Interface
Parameters:
- `SIZE`, 7, bin counter width; matches `histogram_unit` `SIZE`
- `MAX_NUMBER`, 127, highest bin index; bins are `0..MAX_NUMBER`
- `ADDR_W`, `$clog2(MAX_NUMBER)`, derived; bin address width

Ports (reset is asynchronous, active-low; `RST` low forces reset immediately, independent of `CLK`):
- `CLK`  in  1  system clock, all state on rising edge
- `RST`  in  1  asynchronous active-low reset
- `START`  in  1  sweep request, sampled only in IDLE
- `rd_addr`  out  `ADDR_W`  bin address to histogram memory
- `rd_data`  in  `SIZE`  bin count, valid one cycle after `rd_addr`
- `BUSY`  out  1  high during READ and DRAIN
- `DONE`  out  1  one-cycle pulse, results valid
- `peak_bin`  out  `ADDR_W`  index of largest bin
- `peak_count`  out  `SIZE`  count of largest bin
- `total`  out  `SIZE+ADDR_W`  sum of all bins
- `nonzero_bins`  out  `ADDR_W+1`  number of bins with count > 0

## Operation
- FSM states: IDLE, READ, DRAIN, FIN.
  - IDLE -> READ on `START`=1.
  - READ -> DRAIN after the address `MAX_NUMBER` has been issued.
  - DRAIN -> FIN unconditionally.
  - FIN -> IDLE unconditionally.
- On leaving IDLE, internal accumulators clear: running max = 0, running index = 0, sum = 0, nonzero count = 0.
- In READ, `rd_addr` steps 0, 1, …, `MAX_NUMBER`, one address per cycle. In DRAIN, `rd_addr` holds `MAX_NUMBER`. In IDLE and FIN, `rd_addr` = 0.
- Each cycle after the first READ cycle, up to and including DRAIN, the block consumes `rd_data` for the previous address:
  - sum += `rd_data`
  - `nonzero_bins` accumulator += 1 if `rd_data` != 0
  - if `rd_data` > running max (strictly greater), update max and index.
- Tie rule: the lowest bin index wins.
- All-zero histogram: `peak_bin` = 0, `peak_count` = 0, `total` = 0, `nonzero_bins` = 0.
- Result outputs (`peak_bin`, `peak_count`, `total`, `nonzero_bins`) are registered:
  - they load on the edge entering FIN, including the final sample;
  - they hold until the next FIN, and stay stable through a following sweep.
- Width rules:
  - `total` max = (`MAX_NUMBER`+1)·(2^`SIZE`−1) = 16256 for defaults; it fits in `SIZE+ADDR_W` with no overflow.
  - `nonzero_bins` max = `MAX_NUMBER`+1 = 128, which needs `ADDR_W+1` bits.
- `START` is ignored in READ, DRAIN and FIN; it is not queued.
- Reset (any time, including mid-sweep):
  - state returns to IDLE;
  - `rd_addr`, `BUSY`, `DONE` = 0;
  - all result outputs = 0;
  - no `DONE` is issued for an aborted sweep.

## Timing
- Let E0 be the edge that samples `START`=1 in IDLE.
- After E0: `BUSY`=1 and `rd_addr`=0.
- After edge E_k (k = 1..`MAX_NUMBER`): `rd_addr` = k, and `rd_data` for address k−1 is captured at E_k.
- After E_(`MAX_NUMBER`+1): state is DRAIN, and the data for `MAX_NUMBER` is on `rd_data`.
- After E_(`MAX_NUMBER`+2): state is FIN, `DONE`=1, `BUSY`=0, results updated.
- Latency is `MAX_NUMBER`+2 = 129 cycles from E0 to `DONE`. `BUSY` is high for 129 cycles.
- Next E: back in IDLE, `DONE`=0. The earliest new `START` is sampled on the edge after FIN, so consecutive sweeps have a 131-cycle period (`START` held high continuously).
- `rd_data` is sampled exactly one cycle after its address; no combinational path from `rd_data` to any output.

## Test plan
- Reset then all-zero memory, one `START` pulse -> `DONE` exactly 129 cycles after the START-sampling edge; `peak_bin`=0, `peak_count`=0, `total`=0, `nonzero_bins`=0; `rd_addr` sequence 0..127 observed.
- Memory with bin 37 = 90 and all others = 5 -> `peak_bin`=37, `peak_count`=90, `total`=725, `nonzero_bins`=128.
- Ties: bins 10 and 100 both = 127, others 0 -> `peak_bin`=10, `peak_count`=127, `total`=254, `nonzero_bins`=2.
- Saturation: all bins = 127 -> `total`=16256, `peak_bin`=0, `nonzero_bins`=128, no wrap.
- `START` pulsed at cycles 5, 60 and 128 of a sweep -> a single `DONE`; results match memory; `BUSY` never drops early.
- `RST` pulled low at cycle 64 of a sweep with previous results `peak_bin`=37 -> all outputs 0 immediately (asynchronous); no `DONE`; a fresh `START` gives correct results after 129 cycles.
